// File: rtl/ldl_round_wrr.sv
// rtl/ldl_round_wrr.sv - weighted round-robin arbiter with registered grant and valid/ready handoff
//
// Grants one of WIDTH requesters for up to weight[owner] accepted beats,
// then rotates the priority pointer to owner+1 (explicit wrap, so WIDTH
// need not be a power of two).
//
// Parameters:
//   WIDTH     number of requesters (2..64)
//   WEIGHT_W  width of each per-channel weight field
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   req     per-channel request level, held until served
//   weight  channel i weight at [i*WEIGHT_W +: WEIGHT_W], sampled at grant
//   ready   sink accepts the current beat
//   lock    per-channel burst lock (only with LDL_ROUND_WRR_LOCK_EN)
//   valid   a beat is offered (GRANT and req[owner])
//   bin     registered owner index
//   hot     registered one-hot owner, zero in IDLE
// Optional feature macro: LDL_ROUND_WRR_LOCK_EN
module ldl_round_wrr #(
  parameter int WIDTH    = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            req,
  input  logic [WIDTH*WEIGHT_W-1:0]   weight,
  input  logic                        ready,
`ifdef LDL_ROUND_WRR_LOCK_EN
  input  logic [WIDTH-1:0]            lock,
`endif
  output logic                        valid,
  output logic [$clog2(WIDTH)-1:0]    bin,
  output logic [WIDTH-1:0]            hot
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WIDTH-1:0]    hot_q, hot_d;

  logic                found;
  logic [IW-1:0]       sel;
  int                  scan_idx;
  logic [WEIGHT_W-1:0] sel_weight;
  logic [WEIGHT_W-1:0] wt_eff;
  logic [IW-1:0]       ptr_after_owner;
  logic                lock_owner;

  // Priority scan starting at ptr, wrapping by compare so indices >= WIDTH
  // are never produced.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = 0;
    for (int i = 0; i < WIDTH; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= WIDTH) scan_idx = scan_idx - WIDTH;
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        sel   = IW'(scan_idx);
      end
    end
  end

  assign sel_weight      = weight[sel*WEIGHT_W +: WEIGHT_W];
  // A zero weight still earns one beat so the channel is not skipped.
  assign wt_eff          = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;
  assign ptr_after_owner = (owner_q == IW'(WIDTH - 1)) ? '0 : owner_q + 1'b1;

`ifdef LDL_ROUND_WRR_LOCK_EN
  assign lock_owner = lock[owner_q];
`else
  assign lock_owner = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    hot_d    = hot_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          owner_d    = sel;
          credit_d   = wt_eff;
          hot_d      = '0;
          hot_d[sel] = 1'b1;
        end
      end
      GRANT: begin
        // A dropped request releases even if a last beat coincides.
        if (!req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = ptr_after_owner;
          hot_d   = '0;
        end else if (ready) begin
          if (credit_q == WEIGHT_W'(1)) begin
            // Locked packets keep the grant at the last credit.
            if (!lock_owner) begin
              state_d = IDLE;
              ptr_d   = ptr_after_owner;
              hot_d   = '0;
            end
          end else begin
            credit_d = credit_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
      hot_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      hot_q    <= hot_d;
    end
  end

  // bin tracks owner, which only changes at grant, so it holds across release.
  assign valid = (state_q == GRANT) && req[owner_q];
  assign bin   = owner_q;
  assign hot   = hot_q;

endmodule

// File: doc/ldl_round_wrr.md
# ldl_round_wrr

Weighted round-robin arbiter with registered grant and a downstream valid/ready handshake. It is the successor to the single-cycle round-robin arbiter. The grant is held for up to a per-channel weight of accepted beats before rotating, and non-power-of-two channel counts are supported. It sits between WIDTH request sources and one shared sink (bus port, FIFO write side) and arbitrates transfers, not single cycles.

## Interface
- WIDTH, 8, number of requesters; legal range 2..64, power of two not required.
- WEIGHT_W, 4, width of each channel's weight field.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low (0 is reset).
- req  input  WIDTH  per-channel request; level, held until served.
- weight  input  WIDTH*WEIGHT_W  channel i weight at [i*WEIGHT_W +: WEIGHT_W].
  - Quasi-static.
  - Sampled only when a grant is issued.
- ready  input  1  sink accepts the current beat.
- lock  input  WIDTH  per-channel burst lock; present only with LDL_ROUND_WRR_LOCK_EN.
- valid  output  1  a beat is offered: state GRANT and req[owner]=1.
- bin  output  $clog2(WIDTH)  registered index of the owning channel.
- hot  output  WIDTH  registered one-hot of the owner; all-zero in IDLE.

## Operation
- Two states, IDLE and GRANT.
- Registers: state, ptr (next priority index, 0..WIDTH-1), owner, credit (WEIGHT_W bits).
- Reset: state=IDLE, ptr=0, owner=0, credit=0, valid=0, bin=0, hot=0.
- IDLE, no req bit set: stay in IDLE; ptr unchanged.
- IDLE, any req bit set: select the first set bit scanning ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1.
  - Load owner with that index.
  - Load credit with weight[owner]; a weight of 0 is treated as 1.
  - Next state GRANT.
- GRANT, transfer (valid & ready):
  - If credit==1: release.
  - Otherwise: credit decrements.
- GRANT, req[owner]==0: release. Dropping a request forfeits the remaining credit.
- Release:
  - Next state IDLE.
  - ptr = owner+1, wrapping WIDTH-1 -> 0 explicitly (not modulo 2^n).
  - hot clears.
  - bin holds its last value.
- A requester is never starved: a channel gets at most its weight in beats per rotation.
- Pointer wrap uses a compare against WIDTH-1, never bit truncation; this matters when WIDTH is not a power of two.
- Requests to bits at index >= WIDTH do not exist. Weight fields are unsigned.

## Timing
- Arbitration latency:
  - req rising in IDLE at cycle n gives hot/bin valid at n+1.
  - valid rises at n+1 if req[owner] is still set.
- valid is combinational from req[owner] and state. ready may depend combinationally on valid; valid must not depend on ready.
- Release costs exactly one IDLE cycle, so at most one beat every two cycles at a rotation boundary. A back-to-back single-owner burst of W beats takes W cycles with ready held high.
- Simultaneous last beat and req[owner] falling in the same cycle counts as one release; ptr=owner+1.
- If ready stays low, the grant is held indefinitely and credit does not change.
- rst_n asserted mid-burst:
  - All registers clear immediately (asynchronous).
  - Outputs are 0 in the same cycle, without waiting for a clock edge.
- rst_n deassertion is expected to be synchronised externally.

## Configuration
- LDL_ROUND_WRR_LOCK_EN defined:
  - The lock input exists.
  - In GRANT, a transfer with credit==1 and lock[owner]=1 does not release; credit stays 1.
  - Release happens on the first transfer with lock[owner]=0, or when req[owner] drops.
  - Used for indivisible packets longer than the weight.
- Not defined:
  - No lock port.
  - Behaviour is identical to lock tied to all-zero.

## Test plan
- Rotation, WIDTH=4, WEIGHT_W=3, all weights=1, req=4'b1111, ready=1:
  - Grants cycle 0,1,2,3,0.
  - valid pattern 1,0,1,0,...
- Weighted, weights {3,1,2,1}, req=4'b0101, ready=1: beats ch0,ch0,ch0 (IDLE) ch2,ch2 (IDLE) ch0...
- Non-power-of-two, WIDTH=5, req=5'b10001, weights 1: grants alternate 4,0,4; ptr never reaches 5..7.
- Request drop and backpressure:
  - ch1 granted with weight 4; ready=0 for 3 cycles, then req[1]=0.
  - Required: credit stays 4, release next cycle, ptr=2.
- Async reset mid-grant:
  - Assert rst_n=0 between clock edges.
  - Required: hot=0, bin=0, valid=0 immediately; after release, with req=4'b1000, first grant is ch3 at ptr scan from 0.
- With LDL_ROUND_WRR_LOCK_EN, ch0 weight 1, lock[0] high for 3 beats:
  - ch0 gets 4 beats; release after the beat with lock[0]=0.
  - Without the macro, same stimulus yields 1 beat.
